// File: rtl/hs_arb_pkg.sv
// hs_arb_pkg: shared types and sizing for the hiscore / CPU work-RAM arbiter.
package hs_arb_pkg;

    // Ownership phases of the work-RAM port.
    typedef enum logic [2:0] {
        IDLE,
        PAUSE,
        SETTLE,
        GRANT,
        RELEASE
    } hs_arb_state_t;

    // Guard counter for SETTLE/RELEASE, sized for intervals up to 8 cycles.
    localparam int GUARD_CNT_W = 3;

    // Pause-acknowledge wait counter (only built with the timeout feature).
    localparam int WAIT_CNT_W = 17;

endpackage

// File: rtl/hs_arb_mux.sv
// hs_arb_mux: combinational work-RAM port mux. The CPU drives the port in
// IDLE/PAUSE, the hiscore engine drives it in GRANT, and writes are blocked
// in the SETTLE/RELEASE guard intervals so neither side can corrupt RAM
// while ownership changes hands.
module hs_arb_mux
    import hs_arb_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 8
) (
    input  hs_arb_state_t   state,
    input  logic [AW-1:0]   cpu_addr,
    input  logic [DW-1:0]   cpu_din,
    input  logic            cpu_we,
    input  logic [AW-1:0]   hs_address,
    input  logic [DW-1:0]   hs_data_in,
    input  logic            hs_write,
    input  logic [DW-1:0]   ram_dout,
    output logic [DW-1:0]   cpu_dout,
    output logic [AW-1:0]   ram_addr,
    output logic [DW-1:0]   ram_din,
    output logic            ram_we
);

    // The CPU always sees RAM read data; it is halted whenever it is not the owner.
    assign cpu_dout = ram_dout;

    // Select the port owner and gate the write strobe from the registered state.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        ram_addr = cpu_addr;
        ram_din  = cpu_din;
        ram_we   = cpu_we;
        case (state)
            IDLE, PAUSE: begin
                ram_we = cpu_we;
            end
            GRANT: begin
                ram_addr = hs_address;
                ram_din  = hs_data_in;
                ram_we   = hs_write;
            end
            default: begin
                ram_we = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/hs_ram_arbiter.sv
// hs_ram_arbiter: shares the game work-RAM port between the CPU and the
// hiscore engine. A hiscore access intent raises a CPU pause request; once
// the pause is acknowledged and the CPU bus has settled, the port is handed
// to the hiscore engine, and it goes back to the CPU after a guard interval.
// Optional feature: define HS_ARB_TIMEOUT_EN to abort a pause request that is
// not acknowledged within TIMEOUT_CYC cycles (pulses hs_timeout).
module hs_ram_arbiter
    import hs_arb_pkg::*;
#(
    parameter int AW          = 16,
    parameter int DW          = 8,
    parameter int SETTLE_CYC  = 2,
    parameter int RELEASE_CYC = 2,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic            clk_sys,
    input  logic            reset,
    input  logic [AW-1:0]   cpu_addr,
    input  logic [DW-1:0]   cpu_din,
    input  logic            cpu_we,
    output logic [DW-1:0]   cpu_dout,
    input  logic [AW-1:0]   hs_address,
    input  logic [DW-1:0]   hs_data_in,
    input  logic            hs_write,
    input  logic            hs_access_read,
    input  logic            hs_access_write,
    output logic [DW-1:0]   hs_data_out,
    output logic            hs_pause,
    input  logic            cpu_paused,
    output logic [AW-1:0]   ram_addr,
    output logic [DW-1:0]   ram_din,
    output logic            ram_we,
    input  logic [DW-1:0]   ram_dout,
    output logic            hs_granted,
    output logic            hs_timeout
);

    localparam logic [GUARD_CNT_W-1:0] SETTLE_LAST  = GUARD_CNT_W'(SETTLE_CYC - 1);
    localparam logic [GUARD_CNT_W-1:0] RELEASE_LAST = GUARD_CNT_W'(RELEASE_CYC - 1);

    // Reject configurations the guard and wait counters cannot represent.
    generate
        if (SETTLE_CYC < 1 || SETTLE_CYC > 8 || RELEASE_CYC < 1 || RELEASE_CYC > 8 ||
            TIMEOUT_CYC < 1 || TIMEOUT_CYC > 131071) begin : g_bad_params
            $error("hs_ram_arbiter: SETTLE_CYC/RELEASE_CYC must be 1..8, TIMEOUT_CYC 1..131071");
        end
    endgenerate

    hs_arb_state_t          state;
    logic [GUARD_CNT_W-1:0] cnt;
    logic                   intent;
    logic                   pause_ok;

    assign intent = hs_access_read | hs_access_write;

`ifdef HS_ARB_TIMEOUT_EN
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(TIMEOUT_CYC - 1);

    logic [WAIT_CNT_W-1:0]  wait_cnt;
    logic                   reentry_block;
    logic                   hs_timeout_q;

    // After an abort, a new pause request needs a fresh intent edge.
    assign pause_ok   = intent && !reentry_block;
    assign hs_timeout = hs_timeout_q;
`else
    assign pause_ok   = intent;
    assign hs_timeout = 1'b0;
`endif

    // Ownership FSM with registered pause/grant outputs and hiscore read capture.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            hs_pause    <= 1'b0;
            hs_granted  <= 1'b0;
            hs_data_out <= '0;
`ifdef HS_ARB_TIMEOUT_EN
            wait_cnt      <= '0;
            reentry_block <= 1'b0;
            hs_timeout_q  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads the pre-edge state.
`ifdef HS_ARB_TIMEOUT_EN
            hs_timeout_q <= 1'b0;
            if (!intent) begin
                reentry_block <= 1'b0;
            end
`endif
            if (state == GRANT) begin
                hs_data_out <= ram_dout;
            end

            case (state)
                IDLE: begin
                    if (pause_ok) begin
                        state    <= PAUSE;
                        hs_pause <= 1'b1;
`ifdef HS_ARB_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end
                PAUSE: begin
                    if (!intent) begin
                        state    <= IDLE;
                        hs_pause <= 1'b0;
                    end else if (cpu_paused) begin
                        state <= SETTLE;
                        cnt   <= '0;
                    end
`ifdef HS_ARB_TIMEOUT_EN
                    else if (wait_cnt == WAIT_LAST) begin
                        state         <= IDLE;
                        hs_pause      <= 1'b0;
                        hs_timeout_q  <= 1'b1;
                        reentry_block <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        state      <= GRANT;
                        hs_granted <= 1'b1;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GRANT: begin
                    // A dropped cpu_paused is ignored here: the pause block owns the CPU halt.
                    if (!intent) begin
                        state      <= RELEASE;
                        hs_granted <= 1'b0;
                        cnt        <= '0;
                    end
                end
                RELEASE: begin
                    // The CPU is still halted, so a returning intent is re-granted without a new pause.
                    if (intent) begin
                        state      <= GRANT;
                        hs_granted <= 1'b1;
                    end else if (cnt == RELEASE_LAST) begin
                        state    <= IDLE;
                        hs_pause <= 1'b0;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    hs_pause   <= 1'b0;
                    hs_granted <= 1'b0;
                end
            endcase
        end
    end

    hs_arb_mux #(
        .AW (AW),
        .DW (DW)
    ) u_mux (
        .state      (state),
        .cpu_addr   (cpu_addr),
        .cpu_din    (cpu_din),
        .cpu_we     (cpu_we),
        .hs_address (hs_address),
        .hs_data_in (hs_data_in),
        .hs_write   (hs_write),
        .ram_dout   (ram_dout),
        .cpu_dout   (cpu_dout),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_we     (ram_we)
    );

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// tb_hs_ram_arbiter: directed and randomized bench for hs_ram_arbiter.
// Expected RAM contents come from a scoreboard of legitimate writes; timing
// expectations come from the cycle arithmetic of the ownership handover.
module tb_hs_ram_arbiter;

    localparam int AW          = 16;
    localparam int DW          = 8;
    localparam int SETTLE_CYC  = 2;
    localparam int RELEASE_CYC = 2;
    localparam int TIMEOUT_CYC = 16;

    logic            clk_sys;
    logic            reset;
    logic [AW-1:0]   cpu_addr;
    logic [DW-1:0]   cpu_din;
    logic            cpu_we;
    logic [DW-1:0]   cpu_dout;
    logic [AW-1:0]   hs_address;
    logic [DW-1:0]   hs_data_in;
    logic            hs_write;
    logic            hs_access_read;
    logic            hs_access_write;
    logic [DW-1:0]   hs_data_out;
    logic            hs_pause;
    logic            cpu_paused;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_din;
    logic            ram_we;
    logic [DW-1:0]   ram_dout;
    logic            hs_granted;
    logic            hs_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    hs_ram_arbiter #(
        .AW          (AW),
        .DW          (DW),
        .SETTLE_CYC  (SETTLE_CYC),
        .RELEASE_CYC (RELEASE_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk_sys         (clk_sys),
        .reset           (reset),
        .cpu_addr        (cpu_addr),
        .cpu_din         (cpu_din),
        .cpu_we          (cpu_we),
        .cpu_dout        (cpu_dout),
        .hs_address      (hs_address),
        .hs_data_in      (hs_data_in),
        .hs_write        (hs_write),
        .hs_access_read  (hs_access_read),
        .hs_access_write (hs_access_write),
        .hs_data_out     (hs_data_out),
        .hs_pause        (hs_pause),
        .cpu_paused      (cpu_paused),
        .ram_addr        (ram_addr),
        .ram_din         (ram_din),
        .ram_we          (ram_we),
        .ram_dout        (ram_dout),
        .hs_granted      (hs_granted),
        .hs_timeout      (hs_timeout)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Work RAM: one-cycle synchronous read, read-before-write.
    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    always @(posedge clk_sys) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    // Scoreboard: what RAM should hold, from writes that are allowed to land.
    logic [DW-1:0] ref_mem [int];

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return '0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic set_intent(input logic [1:0] rw);
        {hs_access_read, hs_access_write} = rw;
    endtask

    // CPU-owned traffic: the port must follow the CPU; hiscore writes are ignored.
    task automatic cpu_traffic(input int n);
        for (int i = 0; i < n; i++) begin
            cpu_addr   = AW'($urandom_range(16'h8000, 16'h8007));
            cpu_din    = DW'($urandom);
            cpu_we     = 1'($urandom_range(0, 1));
            hs_write   = 1'($urandom_range(0, 1));
            hs_address = AW'($urandom);
            #1;
            check("idle_addr", ram_addr, cpu_addr);
            check("idle_din",  ram_din,  cpu_din);
            check("idle_we",   ram_we,   cpu_we);
            if (cpu_we) ref_mem[int'(cpu_addr)] = cpu_din;
            step();
            check("cpu_dout", cpu_dout, ram_dout);
        end
        cpu_we   = 1'b0;
        hs_write = 1'b0;
    endtask

    // Raise intent, acknowledge after ack_delay cycles, and measure grant latency.
    task automatic acquire(input int ack_delay);
        int n;
        set_intent(2'($urandom_range(1, 3)));
        step();
        check("pause_rise", hs_pause, 1'b1);
        check("pause_no_grant", hs_granted, 1'b0);
        cpu_addr = AW'($urandom_range(16'h8000, 16'h8007));
        cpu_din  = DW'($urandom);
        cpu_we   = 1'b1;
        #1;
        check("pause_cpu_we", ram_we, 1'b1);
        check("pause_cpu_addr", ram_addr, cpu_addr);
        ref_mem[int'(cpu_addr)] = cpu_din;
        for (int i = 1; i < ack_delay; i++) begin
            step();
            cpu_we = 1'b0;
            check("pause_wait", hs_granted, 1'b0);
        end
        cpu_paused = 1'b1;
        step();
        cpu_we = 1'b0;
        check("settle_no_grant", hs_granted, 1'b0);
        cpu_we = 1'b1;
        #1;
        check("settle_we_block", ram_we, 1'b0);
        cpu_we = 1'b0;
        n = 1;
        while (!hs_granted && n < 20) begin
            step();
            n++;
        end
        check("grant_latency", ack_delay + n, ack_delay + 1 + SETTLE_CYC);
        check("grant_pause", hs_pause, 1'b1);
    endtask

    task automatic hs_write_op(input logic [AW-1:0] a, input logic [DW-1:0] d);
        hs_address = a;
        hs_data_in = d;
        hs_write   = 1'b1;
        cpu_addr   = AW'($urandom);
        cpu_we     = 1'($urandom_range(0, 1));
        #1;
        check("grant_wr_addr", ram_addr, a);
        check("grant_wr_din",  ram_din,  d);
        check("grant_wr_we",   ram_we,   1'b1);
        ref_mem[int'(a)] = d;
        step();
        hs_write = 1'b0;
        cpu_we   = 1'b0;
    endtask

    task automatic hs_read_op(input logic [AW-1:0] a);
        logic [DW-1:0] exp;
        hs_address = a;
        hs_write   = 1'b0;
        cpu_we     = 1'b1;
        cpu_addr   = AW'($urandom);
        #1;
        check("grant_cpu_we_block", ram_we, 1'b0);
        check("grant_rd_addr", ram_addr, a);
        exp = ref_rd(a);
        step();
        cpu_we = 1'b0;
        step();
        check("hs_data_out", hs_data_out, exp);
    endtask

    // Drop intent and walk the RELEASE guard back to IDLE.
    task automatic release_all();
        set_intent(2'b00);
        step();
        check("rel_grant_drop", hs_granted, 1'b0);
        check("rel_pause_hold", hs_pause, 1'b1);
        hs_write = 1'b1;
        cpu_we   = 1'b1;
        #1;
        check("rel_we_block", ram_we, 1'b0);
        for (int i = 2; i <= RELEASE_CYC; i++) begin
            step();
            check("rel_pause_hold", hs_pause, 1'b1);
        end
        hs_write = 1'b0;
        cpu_we   = 1'b0;
        step();
        check("rel_pause_drop", hs_pause, 1'b0);
        check("rel_no_grant", hs_granted, 1'b0);
        cpu_paused = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram_mem[i] = '0;
        reset = 1'b1;
        cpu_addr = '0; cpu_din = '0; cpu_we = 1'b0;
        hs_address = '0; hs_data_in = '0; hs_write = 1'b0;
        hs_access_read = 1'b0; hs_access_write = 1'b0; cpu_paused = 1'b0;
        step();
        step();
        check("rst_pause",   hs_pause,    1'b0);
        check("rst_grant",   hs_granted,  1'b0);
        check("rst_timeout", hs_timeout,  1'b0);
        check("rst_dout",    hs_data_out, 8'h00);
        reset = 1'b0;

        cpu_traffic(4);

        // Grant with ack three cycles after intent, then directed write/read.
        acquire(3);
        hs_write_op(16'h8010, 8'hA5);
        hs_write_op(16'h8010, 8'h3C);
        hs_read_op(16'h8010);

        // Intent drops and returns in the first RELEASE cycle: straight back to GRANT.
        set_intent(2'b00);
        step();
        check("regrant_gap", hs_granted, 1'b0);
        check("regrant_pause", hs_pause, 1'b1);
        set_intent(2'b10);
        step();
        check("regrant", hs_granted, 1'b1);
        check("regrant_pause", hs_pause, 1'b1);
        hs_read_op(16'h8010);

        // Pause acknowledge falling during GRANT keeps the grant.
        cpu_paused = 1'b0;
        step();
        step();
        check("ack_drop_hold", hs_granted, 1'b1);
        cpu_paused = 1'b1;
        release_all();

        // Intent drops before the acknowledge: back to IDLE, no grant.
        set_intent(2'b01);
        step();
        check("abort_pause", hs_pause, 1'b1);
        set_intent(2'b00);
        step();
        check("abort_pause_drop", hs_pause, 1'b0);
        check("abort_no_grant", hs_granted, 1'b0);
        cpu_paused = 1'b1;
        step();
        step();
        check("late_ack_ignored", hs_granted, 1'b0);
        check("late_ack_no_pause", hs_pause, 1'b0);
        cpu_paused = 1'b0;
        step();

        // Reset while the hiscore engine holds the port.
        acquire(2);
        reset = 1'b1;
        set_intent(2'b00);
        cpu_paused = 1'b0;
        step();
        check("rst_grant_drop", hs_granted, 1'b0);
        check("rst_pause_drop", hs_pause, 1'b0);
        check("rst_dout_clear", hs_data_out, 8'h00);
        reset = 1'b0;
        cpu_traffic(2);

`ifdef HS_ARB_TIMEOUT_EN
        begin
            int n;
            set_intent(2'b11);
            step();
            check("to_pause", hs_pause, 1'b1);
            n = 0;
            while (!hs_timeout && n < 40) begin
                step();
                n++;
            end
            check("to_latency", n, TIMEOUT_CYC);
            check("to_pause_drop", hs_pause, 1'b0);
            step();
            check("to_pulse_end", hs_timeout, 1'b0);
            for (int i = 0; i < 3; i++) begin
                step();
                check("to_blocked", hs_pause, 1'b0);
            end
            set_intent(2'b00);
            step();
            set_intent(2'b01);
            step();
            check("to_reentry", hs_pause, 1'b1);
            set_intent(2'b00);
            step();
            check("to_reentry_abort", hs_pause, 1'b0);
        end
`else
        check("timeout_tied", hs_timeout, 1'b0);
`endif

        // Randomized sessions: CPU traffic, handover with random ack delay, random accesses.
        for (int s = 0; s < 12; s++) begin
            cpu_traffic(int'($urandom_range(2, 5)));
            acquire(int'($urandom_range(1, 4)));
            for (int k = 0; k < int'($urandom_range(3, 6)); k++) begin
                logic [AW-1:0] a;
                a = AW'($urandom_range(16'h8000, 16'h8007));
                if ($urandom_range(0, 1) == 1) hs_write_op(a, DW'($urandom));
                else hs_read_op(a);
            end
            release_all();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
